prop_host_uart_tx: RTL and testbench

Host-side serial transmitter that drives the Propeller's boot/receive line (pin_in[31]). It is the transmit end of the link the core's P30/P31 serial uses. Use it in place of an external Prop plug for on-chip loaders, self-test and BIST benches. It buffers bytes in a small FIFO, then emits 8N1 frames at a programmable bit rate. Idle line is high.

---
 rtl/prop_host_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_prop_host_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_host_uart_tx.sv
// rtl/prop_host_uart_tx.sv - buffered 8N1 host transmitter driving the Propeller P31 line (optional break: TX_BREAK_EN)
module prop_host_uart_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          res,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
`ifdef TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, fifo_empty;

    state_t           state, state_n;
    logic [DIV_W-1:0] baud, baud_n, div_lat, div_lat_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic             tx_n, go_frame, bit_end;

`ifdef TX_BREAK_EN
    logic [3:0]       brk_bits, brk_bits_n;
    logic             brk_pend, brk_want, go_brk;
    assign brk_want = break_req || brk_pend;
`endif

    // A full FIFO refuses the push even when the same edge pops, so in_ready looks only at count.
    assign in_ready   = !res && (count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count == '0);
    assign fifo_count = count;
    assign bit_end    = (baud == '0);
    assign busy       = (state != IDLE) || !fifo_empty;

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of 2.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef TX_BREAK_EN
    // Remember a short break_req pulse so it is honoured once the current frame finishes.
    always_ff @(posedge clock or posedge res) begin
        if (res)                           brk_pend <= 1'b0;
        else if (go_brk)                   brk_pend <= 1'b0;
        else if (break_req && state != BRK) brk_pend <= 1'b1;
    end
`endif

    // Frame state, bit timer, shifter and the registered line output.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            state   <= IDLE;
            baud    <= '0;
            div_lat <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
`ifdef TX_BREAK_EN
            brk_bits <= '0;
`endif
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            div_lat <= div_lat_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
`ifdef TX_BREAK_EN
            brk_bits <= brk_bits_n;
`endif
        end
    end

    // Next-state logic: each bit lasts div_lat+1 clocks; a new frame latches byte and divisor at pop.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        div_lat_n = div_lat;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        tx_n      = tx;
        go_frame  = 1'b0;
        pop       = 1'b0;
`ifdef TX_BREAK_EN
        go_brk     = 1'b0;
        brk_bits_n = brk_bits;
`endif
        case (state)
            IDLE: begin
                tx_n = 1'b1;
`ifdef TX_BREAK_EN
                if (brk_want) go_brk = 1'b1;
                else
`endif
                if (!fifo_empty) go_frame = 1'b1;
            end
            START: begin
                if (!bit_end) baud_n = baud - 1'b1;
                else begin
                    state_n   = DATA;
                    baud_n    = div_lat;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                end
            end
            DATA: begin
                if (!bit_end) baud_n = baud - 1'b1;
                else if (bit_idx == 3'd7) begin
                    state_n = STOP;
                    baud_n  = div_lat;
                    tx_n    = 1'b1;
                end else begin
                    bit_idx_n = bit_idx + 3'd1;
                    baud_n    = div_lat;
                    tx_n      = shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                end
            end
            STOP: begin
                if (!bit_end) baud_n = baud - 1'b1;
`ifdef TX_BREAK_EN
                else if (brk_want) go_brk = 1'b1;
`endif
                else if (!fifo_empty) go_frame = 1'b1;
                else state_n = IDLE;
            end
`ifdef TX_BREAK_EN
            BRK: begin
                // Ten bit periods minimum (count saturates at 10), then hold while break_req stays high.
                if ((brk_bits == 4'd10 || (bit_end && brk_bits == 4'd9)) && !break_req) begin
                    state_n = STOP;
                    baud_n  = div_lat;
                    tx_n    = 1'b1;
                end else if (brk_bits != 4'd10) begin
                    if (bit_end) begin
                        brk_bits_n = brk_bits + 4'd1;
                        baud_n     = div_lat;
                    end else begin
                        baud_n = baud - 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        if (go_frame) begin
            pop       = 1'b1;
            shreg_n   = mem[rd_ptr];
            div_lat_n = divisor;
            baud_n    = divisor;
            state_n   = START;
            tx_n      = 1'b0;
        end
`ifdef TX_BREAK_EN
        if (go_brk) begin
            div_lat_n  = divisor;
            baud_n     = divisor;
            brk_bits_n = '0;
            state_n    = BRK;
            tx_n       = 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_prop_host_uart_tx.sv
// tb/tb_prop_host_uart_tx.sv - self-checking bench: vector table, hand sequences, random traffic vs. frame-timing model
`timescale 1ns/1ps
module tb_prop_host_uart_tx;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    logic          clock = 1'b0;
    logic          res   = 1'b1;
    logic [DW-1:0] divisor = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, tx, busy;
    logic [4:0]    fifo_count;
`ifdef TX_BREAK_EN
    logic          break_req = 1'b0;
`endif

    always #5 clock = ~clock;

    prop_host_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clock      (clock),
        .res        (res),
        .divisor    (divisor),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
`ifdef TX_BREAK_EN
        .break_req  (break_req),
`endif
        .fifo_count (fifo_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: queue of waiting bytes plus the span [m_s, m_e) of the frame on the line.
    byte unsigned mq[$];
    int           m_s = 0, m_e = 0, m_d = 0;
    logic [7:0]   m_byte = '0;
    logic         chk_en = 1'b0;

    typedef struct {
        int         d;
        logic [7:0] data;
        logic [9:0] pat;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int  cnt;
        bit  pu, po;
        if (res) begin
            mq.delete();
            m_s = 0;
            m_e = 0;
        end else begin
            cnt = mq.size();
            pu  = in_valid && (cnt < DEPTH);
            po  = (cnt > 0) && (cyc >= m_e);
            if (po) begin
                m_byte = mq.pop_front();
                m_s    = cyc;
                m_d    = int'(divisor);
                m_e    = cyc + 10 * (m_d + 1);
            end
            if (pu) mq.push_back(in_data);
        end
    endtask

    task automatic check_model();
        int   cnt, off;
        logic etx, ebusy, eready;
        cnt    = mq.size();
        eready = !res && (cnt < DEPTH);
        ebusy  = !res && ((cyc < m_e) || (cnt > 0));
        etx    = 1'b1;
        if (!res && cyc >= m_s && cyc < m_e) begin
            off = (cyc - m_s) / (m_d + 1);
            if (off == 0)      etx = 1'b0;
            else if (off <= 8) etx = m_byte[off-1];
        end
        chk("model{tx,busy,ready,count}", int'({tx, busy, in_ready, fifo_count}),
            int'({etx, ebusy, eready, 5'(cnt)}));
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        @(negedge clock);
        if (chk_en) check_model();
        #2;
    endtask

    task automatic check_frame(input logic [9:0] pat, input int d, input string name);
        int nb;
        for (int j = 0; j < 10; j++) begin
            nb = 0;
            for (int t = 0; t <= d; t++) begin
                if (tx !== pat[j]) nb++;
                tick();
            end
            chk($sformatf("%s_bit%0d_bad_samples", name, j), nb, 0);
        end
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        divisor  = DW'(v.d);
        in_data  = v.data;
        in_valid = 1'b1;
        tick();
        chk($sformatf("v%0d_accept_tx", idx), tx, 1);
        chk($sformatf("v%0d_accept_count", idx), fifo_count, 1);
        in_valid = 1'b0;
        tick();
        chk($sformatf("v%0d_pop_count", idx), fifo_count, 0);
        check_frame(v.pat, v.d, $sformatf("v%0d", idx));
        chk($sformatf("v%0d_end_busy", idx), busy, 0);
        chk($sformatf("v%0d_end_tx", idx), tx, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid = 1'b0;
        while ((mq.size() > 0 || cyc < m_e) && n < 20000) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, int'(n >= 20000), 0);
        tick();
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_count"}, fifo_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int e0, n, kk;
        vt[0] = '{15, 8'h55, 10'h2AA};
        vt[1] = '{3,  8'hF9, 10'h3F2};
        vt[2] = '{3,  8'h00, 10'h200};
        vt[3] = '{0,  8'hA3, 10'h346};
        vt[4] = '{1,  8'hFF, 10'h3FE};
        vt[5] = '{2,  8'h01, 10'h202};

        #2;
        tick();
        tick();
        chk("reset_tx", tx, 1);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", fifo_count, 0);
        res = 1'b0;
        tick();
        chk("post_reset_in_ready", in_ready, 1);
        chk_en = 1'b1;

        for (int i = 0; i < 6; i++) run_vector(vt[i], i);

        // Back-to-back frames with no idle gap.
        divisor  = 16'd3;
        in_data  = 8'hF9;
        in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        check_frame(10'h3F2, 3, "b2b_first");
        check_frame(10'h200, 3, "b2b_second");
        chk("b2b_end_busy", busy, 0);

        // Divisor change while a frame is in flight applies to the next frame only.
        divisor  = 16'd7;
        in_data  = 8'h0F;
        in_valid = 1'b1;
        tick();
        in_data = 8'hC4;
        tick();
        in_valid = 1'b0;
        divisor  = 16'd3;
        check_frame(10'h21E, 7, "div_old");
        check_frame(10'h388, 3, "div_new");
        chk("div_end_busy", busy, 0);

        // FIFO full while a slow frame holds the line.
        divisor  = 16'd1000;
        in_data  = 8'h10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        divisor = 16'd0;
        for (int i = 0; i < 16; i++) begin
            in_data  = 8'(8'h20 + i);
            in_valid = 1'b1;
            tick();
        end
        in_data = 8'h30;
        chk("full_in_ready", in_ready, 0);
        chk("full_count", fifo_count, 16);
        e0 = m_e;
        n  = 0;
        while (cyc < e0 && n < 12000) begin
            tick();
            n++;
        end
        chk("full_wait_timeout", int'(n >= 12000), 0);
        chk("full_pop_count", fifo_count, 15);
        chk("full_ready_rises", in_ready, 1);
        tick();
        chk("full_late_push_count", fifo_count, 16);
        drain("full");

        // Asynchronous reset in the middle of a data bit with bytes queued.
        divisor  = 16'd3;
        in_data  = 8'hA3;
        in_valid = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset_count", fifo_count, 5);
        res = 1'b1;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_count", fifo_count, 0);
        chk("async_reset_in_ready", in_ready, 0);
        chk("async_reset_busy", busy, 0);
        tick();
        res = 1'b0;
        tick();
        chk("after_reset_in_ready", in_ready, 1);
        chk("after_reset_tx", tx, 1);
        for (int i = 0; i < 12; i++) tick();
        chk("after_reset_no_residual", busy, 0);

        // Random traffic and divisor changes against the model.
        for (int seg = 0; seg < 3; seg++) begin
            divisor = DW'($urandom_range(0, 4));
            for (int i = 0; i < 600; i++) begin
                in_valid = ($urandom % 3) == 0;
                in_data  = 8'($urandom);
                if (($urandom % 200) == 0) divisor = DW'($urandom_range(0, 4));
                tick();
            end
            drain($sformatf("rand%0d", seg));
        end

`ifdef TX_BREAK_EN
        // Short break pulse mid-frame: frame finishes, 10 bit periods of space, 1 of mark, then queued byte.
        chk_en   = 1'b0;
        divisor  = 16'd3;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        tick();
        kk = cyc;
        in_data = 8'h3C;
        tick();
        in_valid  = 1'b0;
        break_req = 1'b1;
        tick();
        tick();
        break_req = 1'b0;
        n = 0;
        while (cyc < kk + 41 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        for (int t = 0; t < 40; t++) begin
            if (tx !== 1'b0) n++;
            tick();
        end
        chk("brk_space_bad_samples", n, 0);
        n = 0;
        for (int t = 0; t < 4; t++) begin
            if (tx !== 1'b1) n++;
            tick();
        end
        chk("brk_mark_bad_samples", n, 0);
        chk("brk_next_start_bit", tx, 0);
        chk("brk_next_busy", busy, 1);
`else
        kk = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
